joybus_device: RTL and testbench

JOYBUS_DEVICE -- requirements
Module: joybus_device

---
 rtl/joybus_pkg.sv | 29 ++
 rtl/joybus_in_sync.sv | 35 +++
 rtl/joybus_device.sv | 184 ++++++++++++++++++
 tb/tb_joybus_device.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/joybus_pkg.sv
// Shared definitions for the Joybus device: FSM states, command codes,
// reply constants and a small sizing helper.
package joybus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_WAIT,
    ST_RX_SAMPLE,
    ST_RX_STOP,
    ST_TURN,
    ST_TX_LOW,
    ST_TX_HIGH,
    ST_TX_STOP
  } state_e;

  localparam logic [7:0]  CMD_INFO   = 8'h00;
  localparam logic [7:0]  CMD_POLL   = 8'h01;
  localparam logic [7:0]  CMD_RESET  = 8'hFF;

  localparam logic [23:0] INFO_REPLY = 24'h050002;

  localparam int unsigned INFO_LEN   = 24;
  localparam int unsigned POLL_LEN   = 32;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/joybus_in_sync.sv
// Joybus line input conditioning: 2-flop synchronizer plus falling-edge detect.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   jb_in      - raw asynchronous open-drain line
//   jb_sync    - synchronized line level
//   jb_fall_c  - combinational falling-edge strobe on the synchronized line
module joybus_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic jb_in,
  output logic jb_sync,
  output logic jb_fall_c
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Flops reset high so an idle (pulled-up) line never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= jb_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign jb_sync   = r_s2;
  assign jb_fall_c = r_s3 & ~r_s2;

endmodule

// File: rtl/joybus_device.sv
// Joybus device endpoint: receives a host command byte, answers INFO/RESET
// with the fixed info reply and POLL with a snapshot of btn_state.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   jb_in      - raw line input
//   jb_oe      - 1 pulls the line low
//   btn_state  - controller status returned by POLL, MSB first
//   cmd_valid  - one-cycle pulse on a complete, correctly stopped command
//   cmd_byte   - last received command byte
//   busy       - high whenever the FSM is not idle
module joybus_device
  import joybus_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 25,
  parameter int unsigned TURN_US    = 2,
  parameter int unsigned GAP_US     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jb_in,
  output logic        jb_oe,
  input  logic [31:0] btn_state,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy
);

  localparam int unsigned CNT_MAX = max_u(max_u(GAP_US, 4), TURN_US) * CLK_PER_US;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] T_US1 = CNT_W'(CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_US2 = CNT_W'(2 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_US3 = CNT_W'(3 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_TRN = CNT_W'(TURN_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_GAP = CNT_W'(GAP_US * CLK_PER_US - 1);

  localparam logic [5:0] INFO_LAST = 6'(INFO_LEN - 1);
  localparam logic [5:0] POLL_LAST = 6'(POLL_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [5:0]       r_tx_last, w_tx_last_nxt;
  logic [7:0]       r_rx_sh, w_rx_sh_nxt;
  logic [31:0]      r_tx_sh, w_tx_sh_nxt;
  logic [7:0]       r_cmd_byte, w_cmd_byte_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic             r_jb_oe, r_busy;

  logic             w_line;
  logic             w_fall;
  logic [CNT_W-1:0] w_lo_end;
  logic [CNT_W-1:0] w_hi_end;

  joybus_in_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .jb_in     (jb_in),
    .jb_sync   (w_line),
    .jb_fall_c (w_fall)
  );

  // Phase lengths for the reply bit currently at the top of the shifter.
  assign w_lo_end = r_tx_sh[31] ? T_US1 : T_US3;
  assign w_hi_end = r_tx_sh[31] ? T_US3 : T_US1;

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_tx_last   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_cmd_byte  <= '0;
      r_cmd_valid <= 1'b0;
      r_jb_oe     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tx_last   <= w_tx_last_nxt;
      r_rx_sh     <= w_rx_sh_nxt;
      r_tx_sh     <= w_tx_sh_nxt;
      r_cmd_byte  <= w_cmd_byte_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_jb_oe     <= (w_state_nxt == ST_TX_LOW) || (w_state_nxt == ST_TX_STOP);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_tx_last_nxt   = r_tx_last;
    w_rx_sh_nxt     = r_rx_sh;
    w_tx_sh_nxt     = r_tx_sh;
    w_cmd_byte_nxt  = r_cmd_byte;
    w_cmd_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt   = ST_RX_SAMPLE;
          w_bit_cnt_nxt = '0;
        end
      end

      // Both wait states time only the line-high interval; a low line resets it.
      ST_RX_WAIT, ST_RX_STOP: begin
        if (w_fall) begin
          w_state_nxt = ST_RX_SAMPLE;
        end else if (w_line) begin
          if (r_cnt == T_GAP) w_state_nxt = ST_IDLE;
          else                w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end

      // Bit count 8 means this sample is the host stop bit.
      ST_RX_SAMPLE: begin
        if (r_cnt != T_US2) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (r_bit_cnt == 6'd8) begin
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
          if (w_line) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_byte_nxt  = r_rx_sh;
            if (r_rx_sh == CMD_INFO || r_rx_sh == CMD_RESET) begin
              w_state_nxt   = ST_TURN;
              w_tx_sh_nxt   = {INFO_REPLY, 8'h00};
              w_tx_last_nxt = INFO_LAST;
            end else if (r_rx_sh == CMD_POLL) begin
              w_state_nxt   = ST_TURN;
              w_tx_sh_nxt   = btn_state;
              w_tx_last_nxt = POLL_LAST;
            end
          end
        end else begin
          w_rx_sh_nxt   = {r_rx_sh[6:0], w_line};
          w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          w_state_nxt   = (r_bit_cnt == 6'd7) ? ST_RX_STOP : ST_RX_WAIT;
        end
      end

      ST_TURN: begin
        if (r_cnt == T_TRN) w_state_nxt = ST_TX_LOW;
        else                w_cnt_nxt   = r_cnt + CNT_W'(1);
      end

      ST_TX_LOW: begin
        if (r_cnt == w_lo_end) w_state_nxt = ST_TX_HIGH;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end

      ST_TX_HIGH: begin
        if (r_cnt == w_hi_end) begin
          w_tx_sh_nxt   = {r_tx_sh[30:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          w_state_nxt   = (r_bit_cnt == r_tx_last) ? ST_TX_STOP : ST_TX_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_TX_STOP: begin
        if (r_cnt == T_US2) w_state_nxt = ST_IDLE;
        else                w_cnt_nxt   = r_cnt + CNT_W'(1);
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign jb_oe     = r_jb_oe;
  assign cmd_valid = r_cmd_valid;
  assign cmd_byte  = r_cmd_byte;
  assign busy      = r_busy;

endmodule

// File: tb/tb_joybus_device.sv
// Directed bench for joybus_device: acts as the Joybus host and decodes replies.
module tb_joybus_device;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_low;
  logic        jb_in;
  logic        jb_oe;
  logic [31:0] btn_state;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;
  logic        toggle_btn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Open-drain line: low if either side pulls.
  assign jb_in = ~(host_low | jb_oe);

  joybus_device #(.CLK_PER_US(25), .TURN_US(2), .GAP_US(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .jb_in     (jb_in),
    .jb_oe     (jb_oe),
    .btn_state (btn_state),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (toggle_btn) btn_state = ~btn_state;
  endtask

  // Host data bits, MSB first: 0 = 75 low/25 high, 1 = 25 low/75 high.
  task automatic send_bits(input logic [7:0] v, input int n);
    logic [7:0] b;
    b = v;
    for (int i = 0; i < n; i++) begin
      host_low = 1'b1;
      repeat (b[7] ? 25 : 75) step();
      host_low = 1'b0;
      repeat (b[7] ? 75 : 25) step();
      b = {b[6:0], 1'b0};
    end
  endtask

  task automatic send_stop(input int lo);
    host_low = 1'b1;
    repeat (lo) step();
    host_low = 1'b0;
  endtask

  // Bounded wait for cmd_valid; stops on the sample where it is seen.
  task automatic wait_valid(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (cmd_valid) seen = 1'b1;
      else           step();
    end
  endtask

  // Decodes a reply starting at the cmd_valid sample. abort_at >= 0 returns
  // at the first low sample of that bit index without finishing.
  task automatic check_reply(input logic [31:0] exp, input int nbits, input int abort_at,
                             input string tag);
    int         n, lo, hi;
    logic [31:0] word;
    logic        b;
    n = 0;
    while (!jb_oe && n < 300) begin step(); n++; end
    check({tag, " turnaround"}, 64'(n), 64'd50);
    word = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) return;
      lo = 0; hi = 0;
      while (jb_oe && lo < 300) begin step(); lo++; end
      while (!jb_oe && hi < 300) begin step(); hi++; end
      b = exp[nbits-1-i];
      check($sformatf("%s bit%0d lo/hi", tag, i), {32'd0, 16'(lo), 16'(hi)},
            b ? {32'd0, 16'd25, 16'd75} : {32'd0, 16'd75, 16'd25});
      word = {word[30:0], (lo < 50)};
    end
    check({tag, " word"}, 64'(word), 64'(exp));
    lo = 0;
    while (jb_oe && lo < 300) begin step(); lo++; end
    check({tag, " stop len"}, 64'(lo), 64'd50);
    check({tag, " busy after stop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen;
    int oe_hits, v_hits;

    rst        = 1'b1;
    host_low   = 1'b0;
    btn_state  = 32'h0;
    toggle_btn = 1'b0;
    repeat (3) step();
    check("reset jb_oe", 64'(jb_oe), 64'd0);
    check("reset cmd_valid", 64'(cmd_valid), 64'd0);
    check("reset cmd_byte", 64'(cmd_byte), 64'h00);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (10) step();

    // Poll with a static status word.
    btn_state = 32'hA5A50F0F;
    send_bits(8'h01, 8); send_stop(25);
    wait_valid(200, seen);
    check("poll cmd_valid", 64'(seen), 64'd1);
    check("poll cmd_byte", 64'(cmd_byte), 64'h01);
    check_reply(32'hA5A50F0F, 32, -1, "poll");
    repeat (20) step();

    // Info and reset both return the fixed 24-bit identity.
    send_bits(8'h00, 8); send_stop(25);
    wait_valid(200, seen);
    check("info cmd_valid", 64'(seen), 64'd1);
    check("info cmd_byte", 64'(cmd_byte), 64'h00);
    check_reply(32'h00050002, 24, -1, "info");
    repeat (20) step();
    send_bits(8'hFF, 8); send_stop(25);
    wait_valid(200, seen);
    check("rstcmd cmd_valid", 64'(seen), 64'd1);
    check("rstcmd cmd_byte", 64'(cmd_byte), 64'hFF);
    check_reply(32'h00050002, 24, -1, "rstcmd");
    repeat (20) step();

    // Unknown command: reported but never answered.
    send_bits(8'h42, 8); send_stop(25);
    wait_valid(200, seen);
    check("unk cmd_valid", 64'(seen), 64'd1);
    check("unk cmd_byte", 64'(cmd_byte), 64'h42);
    check("unk busy", 64'(busy), 64'd0);
    oe_hits = 0; v_hits = 0;
    repeat (200) begin step(); oe_hits += int'(jb_oe); v_hits += int'(cmd_valid); end
    check("unk jb_oe quiet", 64'(oe_hits), 64'd0);
    check("unk single pulse", 64'(v_hits), 64'd0);

    // Truncated command: line held high past the gap limit.
    send_bits(8'hA0, 4);
    v_hits = 0;
    repeat (250) begin step(); v_hits += int'(cmd_valid); end
    check("gap no cmd_valid", 64'(v_hits), 64'd0);
    check("gap busy", 64'(busy), 64'd0);
    check("gap jb_oe", 64'(jb_oe), 64'd0);
    check("gap cmd_byte held", 64'(cmd_byte), 64'h42);

    // Framing error: stop bit reads low.
    send_bits(8'h01, 8); send_stop(75);
    v_hits = 0;
    repeat (150) begin step(); v_hits += int'(cmd_valid); end
    check("framing no cmd_valid", 64'(v_hits), 64'd0);
    check("framing busy", 64'(busy), 64'd0);
    check("framing jb_oe", 64'(jb_oe), 64'd0);

    // Reset during the 10th reply bit.
    btn_state = 32'h0000FFFF;
    send_bits(8'h01, 8); send_stop(25);
    wait_valid(200, seen);
    check("abort cmd_valid", 64'(seen), 64'd1);
    check_reply(32'h0000FFFF, 32, 9, "abort");
    check("abort in low phase", 64'(jb_oe), 64'd1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort jb_oe", 64'(jb_oe), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort cmd_byte", 64'(cmd_byte), 64'h00);
    repeat (20) step();

    // Poll again while the status word toggles every cycle.
    btn_state = 32'h12345678;
    send_bits(8'h01, 8); send_stop(25);
    wait_valid(200, seen);
    check("toggle cmd_valid", 64'(seen), 64'd1);
    check("toggle cmd_byte", 64'(cmd_byte), 64'h01);
    toggle_btn = 1'b1;
    check_reply(32'h12345678, 32, -1, "toggle");
    toggle_btn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
